// File: rtl/coreahb_pkg.sv
// Shared definitions for the AHB-Lite matrix slave-port arbiters.
package coreahb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED   = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  function automatic logic [1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_if.sv
// Request/grant signals between the master side of one slave port and its arbiter.
interface ahb_slave_port_arbiter_if;
  import coreahb_pkg::*;

  logic [NUM_MASTERS-1:0] M_REQ;
  logic [NUM_MASTERS-1:0] M_SEQ;
  logic [NUM_MASTERS-1:0] M_LOCK;
  logic                   HREADY_S;
  logic [NUM_MASTERS-1:0] GRANT;
  logic [NUM_MASTERS-1:0] DP_GRANT;
  logic                   LOCKED;
  logic                   ARB_EVENT;

  modport slave (
    input  M_REQ, M_SEQ, M_LOCK, HREADY_S,
    output GRANT, DP_GRANT, LOCKED, ARB_EVENT
  );

  modport master (
    output M_REQ, M_SEQ, M_LOCK, HREADY_S,
    input  GRANT, DP_GRANT, LOCKED, ARB_EVENT
  );

endinterface

// File: rtl/ahb_rr_pick4.sv
// Four-way rotating priority picker: first set bit of (req & mask) searching upward from ptr+1.
module ahb_rr_pick4
  import coreahb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             ptr,
  input  logic [NUM_MASTERS-1:0] mask,
  output logic [NUM_MASTERS-1:0] pick
);

  logic [NUM_MASTERS-1:0] cand;
  logic [1:0]             idx;
  logic                   found;

  always_comb begin
    cand  = req & mask;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = ptr + 2'(k);
      if (!found && cand[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave-port address-phase arbiter with burst/lock hold and data-phase owner tracking.
//   state     | meaning
//   ST_IDLE   | no address-phase owner, GRANT == 0
//   ST_OWNED  | unlocked owner
//   ST_LOCKED | owner is holding a locked sequence
module ahb_slave_port_arbiter
  import coreahb_pkg::*;
#(
  parameter int ARB_MODE   = ARB_RR,
  parameter int HOLD_LIMIT = 0
)
(
  input logic                     HCLK,
  input logic                     HRESETN,
  ahb_slave_port_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_LIMIT);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] dp_grant_q, dp_grant_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [3:0]             hold_cnt_q, hold_cnt_d;
  logic                   arb_event_q, arb_event_d;

  logic [NUM_MASTERS-1:0] pick, mask;
  logic [1:0]             pick_ptr;
  logic [3:0]             hold_next;
  logic                   own_req, own_seq, own_lock, own_done, others_req, hold_expired;

  assign own_req    = |(grant_q & bus.M_REQ);
  assign own_seq    = |(grant_q & bus.M_SEQ);
  assign own_lock   = |(grant_q & bus.M_LOCK);
  assign own_done   = own_req & ~own_seq;
  assign others_req = |(bus.M_REQ & ~grant_q);

  // The hold count compared includes the NONSEQ completing on this edge.
  assign hold_next    = (own_done && hold_cnt_q != 4'd15) ? hold_cnt_q + 4'd1 : hold_cnt_q;
  assign hold_expired = (ARB_MODE == ARB_FIXED) && (HOLD_LIM != 4'd0) &&
                        (hold_next >= HOLD_LIM) && others_req;
  assign mask         = hold_expired ? ~grant_q : '1;
  assign pick_ptr     = (ARB_MODE == ARB_FIXED) ? 2'd3 : rr_ptr_q;

  ahb_rr_pick4 u_pick (
    .req  (bus.M_REQ),
    .ptr  (pick_ptr),
    .mask (mask),
    .pick (pick)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      dp_grant_q  <= '0;
      rr_ptr_q    <= 2'd3;
      hold_cnt_q  <= '0;
      arb_event_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      dp_grant_q  <= dp_grant_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      arb_event_q <= arb_event_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    dp_grant_d  = dp_grant_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    arb_event_d = 1'b0;
    if (bus.HREADY_S) begin
      if ((state_q == ST_LOCKED && own_lock) || (own_req && own_seq)) begin
        grant_d = grant_q;
      end else begin
        grant_d = pick;
      end
      dp_grant_d = own_req ? grant_q : '0;
      if (grant_d == '0) begin
        state_d = ST_IDLE;
      end else if (|(grant_d & bus.M_LOCK)) begin
        state_d = ST_LOCKED;
      end else begin
        state_d = ST_OWNED;
      end
      if (grant_d != grant_q) begin
        hold_cnt_d  = '0;
        arb_event_d = (grant_d != '0);
        if (grant_d != '0) rr_ptr_d = onehot_idx(grant_d);
      end else begin
        hold_cnt_d = hold_next;
      end
    end
  end

  assign bus.GRANT     = grant_q;
  assign bus.DP_GRANT  = dp_grant_q;
  assign bus.LOCKED    = (state_q == ST_LOCKED);
  assign bus.ARB_EVENT = arb_event_q;

  a_grant_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETN) $onehot0(grant_q));

endmodule
